comparador_serial_ctrl: RTL and testbench
=========================================

// Module: comparador_serial_ctrl
//
// PURPOSE
//   Sequences a single 1-bit magnitude-comparison slice to compare two N-bit unsigned operands.
//   Operands are compared serially, MSB first, one bit per clock.
//   The first differing bit decides the result: maior, menor or igual.
//   Serves as the low-area N-bit comparator for the arithmetic datapath; the combinational
//   1-bit slice is instantiated inside.
//
// PARAMETERS
//   N   default 8   operand width in bits; legal range N >= 2
//
// PORTS
//   clk     in   1   system clock, rising edge
//   rst     in   1   asynchronous reset, active-high
//   start   in   1   request; sampled on rising clk edge in IDLE or DONE
//   a       in   N   operand A, captured on the accepting edge
//   b       in   N   operand B, captured on the accepting edge
//   busy    out  1   high while in SHIFT
//   done    out  1   one-cycle pulse, high in the DONE state
//   maior   out  1   registered result: a > b
//   menor   out  1   registered result: a < b
//   igual   out  1   registered result: a == b
//
// BEHAVIOUR
//   - Clocking and reset
//     - One clock domain.
//     - Reset is asynchronous and active-high.
//     - rst=1 forces: state=IDLE, busy=0, done=0, maior=0, menor=0, igual=0.
//     - All-zero result flags mean "no valid result".
//   - FSM states: IDLE, SHIFT, DONE.
//   - IDLE, start=1:
//     - Load sa<=a, sb<=b, cnt<=N-1.
//     - Clear the internal decision flags (dec_gt=0, dec_lt=0).
//     - Go to SHIFT.
//   - SHIFT, every edge:
//     - Slice compares sa[N-1] and sb[N-1].
//     - If dec_gt=0 and dec_lt=0: set dec_gt if slice maior=1, set dec_lt if slice menor=1.
//     - Once either decision flag is set, it is frozen.
//     - Shift sa and sb left by 1.
//     - If cnt==0 go to DONE, else cnt<=cnt-1.
//   - Entry to DONE: registered outputs load maior=dec_gt, menor=dec_lt, igual=~(dec_gt|dec_lt).
//     - Exactly one of the three flags is then high.
//     - The result is held until the next DONE entry or reset.
//   - DONE:
//     - done=1 for this single cycle.
//     - start=1 here is accepted exactly as in IDLE (back-to-back operation).
//     - Otherwise go to IDLE.
//   - Latency: start-accepting edge to done high = N+1 clocks. Throughput = one compare per N+1 clocks.
//   - start in SHIFT is ignored; the operation in flight is unaffected. a and b are don't-care after capture.
//   - Operands equal in all bits: igual=1 after the full N cycles.
//   - cnt width is clog2(N). cnt never wraps: the decrement is blocked when cnt==0.
//   - rst asserted mid-SHIFT:
//     - Aborts immediately and asynchronously; no done pulse; previous result flags cleared.
//     - The first start after rst deasserts behaves normally.
//
// CONFIGURATION
//   - Macro COMPARADOR_EARLY_EXIT_EN.
//   - Defined:
//     - In SHIFT, the first differing bit moves the FSM straight to DONE on that same edge.
//     - Difference at MSB-relative position k (0 = MSB): start-to-done = k+2 clocks.
//     - Equal operands still take N+1 clocks.
//   - Undefined: every compare takes exactly N SHIFT cycles (constant latency N+1).
//   - Result values are identical in both builds; only latency differs.
//
// TESTING  (N=8 unless noted)
//   1. Reset: rst=1 for 2 cycles at any point -> busy=0, done=0, maior=menor=igual=0 immediately,
//      without waiting for clk.
//   2. Equal operands: a=8'hA5, b=8'hA5, start pulse -> done high 9 clocks later; igual=1, maior=0, menor=0;
//      busy high 8 cycles. Same latency with COMPARADOR_EARLY_EXIT_EN.
//   3. MSB decides: a=8'h80, b=8'h7F -> maior=1. Latency 9 clocks without the macro, 2 clocks with
//      COMPARADOR_EARLY_EXIT_EN.
//   4. LSB region: a=8'h01, b=8'h02 -> menor=1. Latency 9 clocks without the macro, 8 clocks with it.
//   5. Busy/back-to-back:
//      - start with a=8'h10, b=8'h20.
//      - Pulse start again at clock 3 with a=8'hFF, b=8'h00 -> ignored; result menor=1.
//      - Hold start=1 during the DONE cycle with a=8'hFF, b=8'h00 -> accepted; next done gives maior=1.
//   6. Abort: start a=8'h0F, b=8'h0E; assert rst at clock 4 of SHIFT -> no done pulse, flags 0.
//      After release, start a=8'h0E, b=8'h0F -> menor=1 at normal latency.

Source files
------------

// File: rtl/comparador_serial_ctrl.sv
// Serial N-bit unsigned magnitude comparator, MSB first, one bit per clock.
// A combinational 1-bit slice looks at the current MSBs of the two shift
// registers. The first bit position where the operands differ decides the
// result (maior / menor / igual).
// Optional build macro COMPARADOR_EARLY_EXIT_EN: when it is defined, the
// first differing bit ends the compare early. Only the latency changes; the
// result is the same in both builds.

module comparador_bit_slice (
  input  logic i_a,
  input  logic i_b,
  output logic o_maior,
  output logic o_menor
);
  assign o_maior = i_a & ~i_b;
  assign o_menor = ~i_a & i_b;
endmodule

module comparador_serial_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         maior,
  output logic         menor,
  output logic         igual
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          r_state;
  logic [N-1:0]    r_sa;
  logic [N-1:0]    r_sb;
  logic [CW-1:0]   r_cnt;
  logic            r_dec_gt;
  logic            r_dec_lt;

  logic            w_gt;
  logic            w_lt;
  logic            w_undecided;
  logic            w_next_gt;
  logic            w_next_lt;
  logic            w_last;

  comparador_bit_slice u_slice (
    .i_a     (r_sa[N-1]),
    .i_b     (r_sb[N-1]),
    .o_maior (w_gt),
    .o_menor (w_lt)
  );

  // Decision flags freeze once set; next values include this edge's slice result
  always_comb begin
    w_undecided = ~(r_dec_gt | r_dec_lt);
    w_next_gt   = r_dec_gt | (w_undecided & w_gt);
    w_next_lt   = r_dec_lt | (w_undecided & w_lt);
`ifdef COMPARADOR_EARLY_EXIT_EN
    w_last      = (r_cnt == '0) || (w_undecided && (w_gt || w_lt));
`else
    w_last      = (r_cnt == '0);
`endif
  end

  // Control FSM with registered status and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_cnt    <= '0;
      r_dec_gt <= 1'b0;
      r_dec_lt <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      maior    <= 1'b0;
      menor    <= 1'b0;
      igual    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_sa     <= a;
            r_sb     <= b;
            r_cnt    <= CW'(N - 1);
            r_dec_gt <= 1'b0;
            r_dec_lt <= 1'b0;
            busy     <= 1'b1;
            r_state  <= SHIFT;
          end else begin
            r_state  <= IDLE;
          end
        end
        SHIFT: begin
          r_dec_gt <= w_next_gt;
          r_dec_lt <= w_next_lt;
          r_sa     <= {r_sa[N-2:0], 1'b0};
          r_sb     <= {r_sb[N-2:0], 1'b0};
          if (w_last) begin
            // Result loads from the flags as updated on this same edge
            maior   <= w_next_gt;
            menor   <= w_next_lt;
            igual   <= ~(w_next_gt | w_next_lt);
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt   <= r_cnt - 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// Self-checking bench for comparador_serial_ctrl (N=8), default or early-exit build.
module tb_comparador_serial_ctrl;
  localparam int N = 8;
  localparam int MAXC = 4 * N;
`ifdef COMPARADOR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic         maior;
  logic         menor;
  logic         igual;

  int vectors = 0;
  int miscompares = 0;

  comparador_serial_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .maior (maior),
    .menor (menor),
    .igual (igual)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] va;
    logic [N-1:0] vb;
    logic         gt;
    logic         lt;
    logic         eq;
    int           lat_full;
    int           lat_early;
  } vec_t;

  vec_t tbl [8];

  // Latency in clocks, counting the accepting cycle as clock 1
  function automatic int model_lat(logic [N-1:0] x, logic [N-1:0] y);
    if (!EARLY || x == y) return N + 1;
    for (int i = N - 1; i >= 0; i--)
      if (x[i] != y[i]) return (N - 1 - i) + 2;
    return N + 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge holding count c0; steps negedges until done or the bound
  task automatic wait_done(input int c0, output int lat, output int busy_cnt);
    lat = c0;
    busy_cnt = 0;
    while (!done && lat < MAXC) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_and_check(input string name, input logic [N-1:0] av, input logic [N-1:0] bv,
                               input logic egt, input logic elt, input logic eeq, input int elat);
    int lat;
    int bc;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~av; b = ~bv;
    wait_done(1, lat, bc);
    check({name, " done"}, int'(done), 1);
    check({name, " latency"}, lat, elat);
    check({name, " busy cycles"}, bc, elat - 1);
    check({name, " maior"}, int'(maior), int'(egt));
    check({name, " menor"}, int'(menor), int'(elt));
    check({name, " igual"}, int'(igual), int'(eeq));
    @(negedge clk);
    check({name, " done pulse width"}, int'(done), 0);
    check({name, " result held"}, int'({maior, menor, igual}), int'({egt, elt, eeq}));
  endtask

  initial begin
    int lat;
    int bc;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    tbl[0] = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 9, 9};
    tbl[1] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 9, 2};
    tbl[2] = '{8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 9, 8};
    tbl[3] = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 9, 2};
    tbl[4] = '{8'hFE, 8'hFF, 1'b0, 1'b1, 1'b0, 9, 9};
    tbl[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 9, 9};
    tbl[6] = '{8'h3C, 8'h34, 1'b1, 1'b0, 1'b0, 9, 6};
    tbl[7] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 9, 9};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #3;
    check("reset outputs", int'({busy, done, maior, menor, igual}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    foreach (tbl[i])
      run_and_check($sformatf("tbl%0d", i), tbl[i].va, tbl[i].vb, tbl[i].gt, tbl[i].lt, tbl[i].eq,
                    EARLY ? tbl[i].lat_early : tbl[i].lat_full);

    // Randomized against arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? ra : N'($urandom_range(0, 255));
      run_and_check($sformatf("rnd%0d", i), ra, rb, ra > rb, ra < rb, ra == rb, model_lat(ra, rb));
    end

    // Start ignored while busy, then accepted during DONE
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, lat, bc);
    check("b2b first latency", lat, model_lat(8'h10, 8'h20));
    check("b2b first menor", int'(menor), 1);
    check("b2b first maior", int'(maior), 0);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b accepted busy", int'(busy), 1);
    check("b2b accepted done", int'(done), 0);
    wait_done(1, lat, bc);
    check("b2b second latency", lat, model_lat(8'hFF, 8'h00));
    check("b2b second maior", int'(maior), 1);
    check("b2b second menor", int'(menor), 0);
    @(negedge clk);

    // Asynchronous abort mid-SHIFT
    a = 8'h0F; b = 8'h0E; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort busy before rst", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("abort async clear", int'({busy, done, maior, menor, igual}), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort no done", int'({busy, done, maior, menor, igual}), 0);
    end
    rst = 1'b0;
    run_and_check("after abort", 8'h0E, 8'h0F, 1'b0, 1'b1, 1'b0, model_lat(8'h0E, 8'h0F));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
